// File: rtl/scaler_up.sv
// scaler_up: two-stage signed left-shift width expander with symmetric clamping
// and saturation statistics (sticky flag plus saturating event counter).

module scaler_up #(
    parameter int IN_WIDTH    = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int SCALE_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    input  logic [IN_WIDTH-1:0]    in_i,
    input  logic [SCALE_WIDTH-1:0] scale_i,
    input  logic                   clear_i,
    output logic                   out_valid_o,
    output logic [OUT_WIDTH-1:0]   out_o,
    output logic                   sat_o,
    output logic                   sat_sticky_o,
    output logic [CNT_WIDTH-1:0]   sat_cnt_o
);

    localparam int SHIFT_MAX = (1 << SCALE_WIDTH) - 1;
    localparam int FULL_W    = IN_WIDTH + SHIFT_MAX;
    localparam int CMP_W     = (FULL_W > OUT_WIDTH) ? FULL_W : OUT_WIDTH;
    localparam int HEAD_W    = CMP_W - OUT_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Exact shift, then clamp: the result fits only if every bit from the
    // output sign position upward agrees. Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] sat_shift(
        input logic [IN_WIDTH-1:0]    x,
        input logic [SCALE_WIDTH-1:0] sh
    );
        logic [CMP_W-1:0]     full;
        logic [HEAD_W-1:0]    head;
        logic [OUT_WIDTH-1:0] val;
        logic                 clip;
        full = {{(CMP_W-IN_WIDTH){x[IN_WIDTH-1]}}, x} << sh;
        head = full[CMP_W-1:OUT_WIDTH-1];
        if ((head == {HEAD_W{1'b0}}) || (head == {HEAD_W{1'b1}})) begin
            val  = full[OUT_WIDTH-1:0];
            clip = 1'b0;
        end else if (full[CMP_W-1]) begin
            val  = OUT_MIN;
            clip = 1'b1;
        end else begin
            val  = OUT_MAX;
            clip = 1'b1;
        end
        return {clip, val};
    endfunction

    logic [IN_WIDTH-1:0]    in_q,        in_d;
    logic [SCALE_WIDTH-1:0] scale_q,     scale_d;
    logic                   vld1_q,      vld1_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_q,       out_d;
    logic                   sat_q,       sat_d;
    logic                   sticky_q,    sticky_d;
    logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;

    logic [OUT_WIDTH:0]     res_s;
    logic                   sat_event_s;

    // Stage 1 capture: every cycle, so in/scale always travel together.
    always_comb begin
        in_d    = in_i;
        scale_d = scale_i;
        vld1_d  = in_valid_i;
    end

    // Stage 2 arithmetic; data holds across bubbles while sat drops to zero.
    always_comb begin
        res_s       = sat_shift(in_q, scale_q);
        sat_event_s = vld1_q & res_s[OUT_WIDTH];
        out_valid_d = vld1_q;
        sat_d       = sat_event_s;
        if (vld1_q) begin
            out_d = res_s[OUT_WIDTH-1:0];
        end else begin
            out_d = out_q;
        end
    end

    // Saturation statistics: a clamp coinciding with clear still counts once.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (sat_event_s) begin
            sticky_d = 1'b1;
            if (clear_i) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (clear_i) begin
            sticky_d = 1'b0;
            cnt_d    = {CNT_WIDTH{1'b0}};
        end else begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
        end
    end

    // Pipeline and statistics registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_q        <= {IN_WIDTH{1'b0}};
            scale_q     <= {SCALE_WIDTH{1'b0}};
            vld1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= {OUT_WIDTH{1'b0}};
            sat_q       <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= {CNT_WIDTH{1'b0}};
        end else begin
            in_q        <= in_d;
            scale_q     <= scale_d;
            vld1_q      <= vld1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_o        = out_q;
    assign sat_o        = sat_q;
    assign sat_sticky_o = sticky_q;
    assign sat_cnt_o    = cnt_q;

    scaler_up_checker #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_checker (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .out_valid_i  (out_valid_q),
        .sat_i        (sat_q),
        .sat_sticky_i (sticky_q),
        .sat_cnt_i    (cnt_q)
    );

endmodule

// Output-relationship invariants for scaler_up.
module scaler_up_checker #(
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk_i,
    input logic                 reset_i,
    input logic                 out_valid_i,
    input logic                 sat_i,
    input logic                 sat_sticky_i,
    input logic [CNT_WIDTH-1:0] sat_cnt_i
);

    a_sat_needs_valid : assert property (@(posedge clk_i) disable iff (reset_i)
        sat_i |-> out_valid_i);

    a_sat_sets_sticky : assert property (@(posedge clk_i) disable iff (reset_i)
        sat_i |-> sat_sticky_i);

    a_cnt_implies_sticky : assert property (@(posedge clk_i) disable iff (reset_i)
        (sat_cnt_i != {CNT_WIDTH{1'b0}}) |-> sat_sticky_i);

endmodule

// File: tb/tb_scaler_up.sv
// Directed + randomized bench for scaler_up (IN=8, OUT=12, SCALE=4, CNT=3)
// against an integer-arithmetic reference model.

module tb_scaler_up;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_i = 8'd0;
    logic [3:0]  scale_i = 4'd0;
    logic        clear_i = 1'b0;
    logic        out_valid_o;
    logic [11:0] out_o;
    logic        sat_o;
    logic        sat_sticky_o;
    logic [2:0]  sat_cnt_o;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic        m_pv = 1'b0;
    logic [7:0]  m_pin = 8'd0;
    logic [3:0]  m_ps = 4'd0;
    logic        e_v = 1'b0;
    logic [11:0] e_out = 12'd0;
    logic        e_sat = 1'b0;
    logic        e_sticky = 1'b0;
    int          e_cnt = 0;
    logic [11:0] last_out;

    scaler_up #(
        .IN_WIDTH    (8),
        .OUT_WIDTH   (12),
        .SCALE_WIDTH (4),
        .CNT_WIDTH   (3)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .in_valid_i   (in_valid_i),
        .in_i         (in_i),
        .scale_i      (scale_i),
        .clear_i      (clear_i),
        .out_valid_o  (out_valid_o),
        .out_o        (out_o),
        .sat_o        (sat_o),
        .sat_sticky_o (sat_sticky_o),
        .sat_cnt_o    (sat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // value = in * 2^scale, clamped to [-2048, 2047]
    function automatic void ref_scale(input logic [7:0] x, input logic [3:0] s,
                                      output logic [11:0] o, output logic st);
        int f;
        f = int'($signed(x)) * (1 << s);
        if (f > 2047) begin
            o = 12'h7FF; st = 1'b1;
        end else if (f < -2048) begin
            o = 12'h800; st = 1'b1;
        end else begin
            o = f[11:0]; st = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [7:0] x,
                              input logic [3:0] s, input logic c);
        logic [11:0] o;
        logic        st;
        if (rst) begin
            m_pv = 1'b0; m_pin = 8'd0; m_ps = 4'd0;
            e_v = 1'b0; e_out = 12'd0; e_sat = 1'b0; e_sticky = 1'b0; e_cnt = 0;
        end else begin
            st = 1'b0;
            if (m_pv) begin
                ref_scale(m_pin, m_ps, o, st);
                e_v = 1'b1; e_out = o; e_sat = st;
            end else begin
                e_v = 1'b0; e_sat = 1'b0;
            end
            if (m_pv && st) begin
                e_sticky = 1'b1;
                e_cnt = c ? 1 : ((e_cnt == 7) ? 7 : e_cnt + 1);
            end else if (c) begin
                e_sticky = 1'b0; e_cnt = 0;
            end
            m_pv = v; m_pin = x; m_ps = s;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid_o), 32'(e_v));
        chk("out", 32'(out_o), 32'(e_out));
        chk("sat", 32'(sat_o), 32'(e_sat));
        chk("sat_sticky", 32'(sat_sticky_o), 32'(e_sticky));
        chk("sat_cnt", 32'(sat_cnt_o), 32'(e_cnt));
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [3:0] s, input logic c);
        @(negedge clk_i);
        in_valid_i = v; in_i = x; scale_i = s; clear_i = c;
        @(posedge clk_i);
        model_edge(1'b0, v, x, s, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1; in_valid_i = 1'b1; in_i = 8'(($urandom_range(0, 255)));
        scale_i = 4'd15; clear_i = 1'b0;
        @(posedge clk_i);
        model_edge(1'b1, 1'b0, 8'd0, 4'd0, 1'b0);
        #1;
        check_all();
        reset_i = 1'b0; in_valid_i = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        do_reset();
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_cnt", 32'(sat_cnt_o), 32'd0);

        // range limits: exact 0x7F0 and exact MIN are not clamps
        drive(1'b1, 8'h7F, 4'd4, 1'b0);
        drive(1'b1, 8'h80, 4'd4, 1'b0);
        chk("range_max_out", 32'(out_o), 32'h7F0);
        chk("range_max_sat", 32'(sat_o), 32'd0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        chk("range_min_out", 32'(out_o), 32'h800);
        chk("range_min_sat", 32'(sat_o), 32'd0);

        // positive clamp
        drive(1'b1, 8'h7F, 4'd5, 1'b0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        chk("pos_clamp_out", 32'(out_o), 32'h7FF);
        chk("pos_clamp_sat", 32'(sat_o), 32'd1);
        chk("pos_clamp_cnt", 32'(sat_cnt_o), 32'd1);

        // negative clamp, then exact MIN from -1 << 11
        drive(1'b1, 8'hFF, 4'd15, 1'b0);
        drive(1'b1, 8'hFF, 4'd11, 1'b0);
        chk("neg_clamp_out", 32'(out_o), 32'h800);
        chk("neg_clamp_sat", 32'(sat_o), 32'd1);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        chk("neg_exact_out", 32'(out_o), 32'h800);
        chk("neg_exact_sat", 32'(sat_o), 32'd0);

        // continuous stream with alternating scale, then a gap
        for (int i = 0; i < 16; i++)
            drive(1'b1, 8'($urandom_range(0, 255)), (i % 2 == 1) ? 4'd3 : 4'd0, 1'b0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        last_out = e_out;
        drive(1'b0, 8'h5A, 4'd7, 1'b0);
        chk("gap_valid", 32'(out_valid_o), 32'd0);
        chk("gap_hold", 32'(out_o), 32'(last_out));

        // counter saturation and clear
        drive(1'b0, 8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 9; i++)
            drive(1'b1, 8'h7F, 4'd15, 1'b0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        chk("cnt_hold", 32'(sat_cnt_o), 32'd7);
        drive(1'b0, 8'h00, 4'd0, 1'b1);
        chk("clear_cnt", 32'(sat_cnt_o), 32'd0);
        chk("clear_sticky", 32'(sat_sticky_o), 32'd0);
        drive(1'b1, 8'h7F, 4'd15, 1'b0);
        drive(1'b0, 8'h00, 4'd0, 1'b1);
        chk("clear_evt_cnt", 32'(sat_cnt_o), 32'd1);
        chk("clear_evt_sticky", 32'(sat_sticky_o), 32'd1);

        // reset with samples in flight
        drive(1'b1, 8'h81, 4'd15, 1'b0);
        do_reset();
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_sticky", 32'(sat_sticky_o), 32'd0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        drive(1'b1, 8'h03, 4'd2, 1'b0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        chk("resume_out", 32'(out_o), 32'd12);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scaler_up.md
Name: scaler_up

Overview:
- Controlled bit-width expansion. Inverse of the existing width-reduction scaler.
- Takes a signed sample of IN_WIDTH bits and shifts it left arithmetically by a runtime scale.
- Produces a signed OUT_WIDTH-bit result. Out-of-range results are clamped.
- Sits after low-width DSP stages, for example before NCO mixing or accumulation. Reports saturation so software can back off the scale.

Parameters:
- IN_WIDTH, 8, input sample width. Require IN_WIDTH <= OUT_WIDTH.
- OUT_WIDTH, 16, output sample width.
- SCALE_WIDTH, 4, width of the shift amount. Shift range is 0..2^SCALE_WIDTH-1.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample strobe.
- in  in  IN_WIDTH  signed input sample.
- scale  in  SCALE_WIDTH  unsigned left-shift amount; sampled together with in when in_valid=1.
- clear  in  1  synchronous clear of sat_sticky and sat_cnt.
- out_valid  out  1  output sample strobe.
- out  out  OUT_WIDTH  signed scaled, saturated sample.
- sat  out  1  this output sample was clamped; aligned with out_valid.
- sat_sticky  out  1  set on any clamped sample; held until clear or reset.
- sat_cnt  out  CNT_WIDTH  number of clamped samples; saturates at all-ones.

Behaviour:
- Reset: when reset=1 at a clk edge, the following all go to 0 on that edge:
  - out, out_valid, sat, sat_sticky, sat_cnt;
  - all internal pipeline registers and valids.
- Reset mid-stream discards in-flight samples. Inputs presented during reset are ignored.
- Pipeline: fixed 2-cycle latency. A sample accepted at edge N appears at edge N+2.
- Stage 1 registers in, scale and in_valid. No bubbles and no backpressure: one sample per cycle is accepted.
- Stage 2 arithmetic:
  - Sign-extend in to IN_WIDTH+2^SCALE_WIDTH-1 bits, then shift left by scale.
  - This gives the exact product full = in*2^scale.
  - MAX = 2^(OUT_WIDTH-1)-1 and MIN = -2^(OUT_WIDTH-1).
  - full > MAX gives out=MAX, sat=1. full < MIN gives out=MIN, sat=1. Otherwise out=full[OUT_WIDTH-1:0], sat=0.
- Boundary values:
  - full exactly equal to MIN or MAX is not saturation.
  - scale=0 gives out = sign-extended in, and sat can never assert.
- Valid handling:
  - out_valid is the in_valid delayed by 2 cycles.
  - When out_valid=0, out holds its last value and sat=0.
  - Stage-2 registers are updated only for valid samples.
- Scale per sample: each sample uses the scale presented with it. Changing scale between consecutive valid samples affects only later samples.
- Statistics, evaluated at stage 2 when out_valid and sat are both set:
  - sat_sticky <= 1;
  - sat_cnt <= sat_cnt+1 if not all-ones, otherwise it holds.
- clear=1 with no coincident event: sat_sticky <= 0, sat_cnt <= 0.
- clear=1 in the same cycle as a saturation event: sat_sticky <= 1, sat_cnt <= 1. The event is not lost.
- clear has no effect on the data pipeline, out or sat.
- reset has priority over clear.

Test Plan (IN_WIDTH=8, OUT_WIDTH=12, SCALE_WIDTH=4, CNT_WIDTH=3):
- Range limits: in=0x7F scale=4 -> 2 cycles later out=2032 (0x7F0), sat=0. In the same run, in=-128 scale=4 -> out=-2048 (0x800), sat=0 (exact MIN, no clamp).
- Positive clamp: in=0x7F scale=5 -> out=2047 (0x7FF), sat=1, sat_sticky=1, sat_cnt=1.
- Negative clamp: in=-1 scale=15 -> out=-2048, sat=1. In the same run, in=-1 scale=11 -> out=-2048, sat=0.
- Continuous stream and gaps: back-to-back valid samples with alternating scale 0/3 -> each output is correct for its own scale at 2-cycle latency. A deasserted in_valid gap -> out_valid=0, and out holds its previous value.
- Counter saturation and clear:
  - 9 clamped samples -> sat_cnt=7 (holds, no wrap).
  - clear with no event -> sat_cnt=0, sat_sticky=0.
  - clear coincident with a clamped output -> sat_cnt=1, sat_sticky=1.
- Reset mid-operation: assert reset for 1 cycle with 2 samples in flight -> no out_valid pulses for those samples; all outputs are 0 after that edge. The stream resumes with a 2-cycle latency.
